// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_segment_scanner_if                                             |
// | Display-side bundle: packed nibbles and load in, digit/anodes out.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface seven_segment_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic                    load;
   logic [3:0]              digit;
   logic [NUM_DIGITS-1:0]   anode;
   logic                    frame_start;

   modport master (
      output value,
      output load,
      input  digit,
      input  anode,
      input  frame_start
   );

   modport slave (
      input  value,
      input  load,
      output digit,
      output anode,
      output frame_start
   );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_segment_scanner                                                |
// | Multiplexed seven-segment scan with dead time and frame pulse.       |
// | Optional leading-zero blanking: SEVSEG_LEADING_ZERO_BLANK_EN.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seven_segment_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 1000
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   seven_segment_scanner_if.slave  bus
);
   localparam int DIV_W  = $clog2(REFRESH_DIV);
   localparam int SLOT_W = $clog2(NUM_DIGITS);

   localparam logic [DIV_W-1:0]      c_div_last  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0]      c_dead      = DIV_W'(DEAD_CYCLES);
   localparam logic [SLOT_W-1:0]     c_slot_last = SLOT_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] c_one       = NUM_DIGITS'(1);

   logic                    r_run;
   logic [DIV_W-1:0]        r_div_cnt;
   logic [SLOT_W-1:0]       r_slot;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [3:0]              r_digit;
   logic [NUM_DIGITS-1:0]   r_anode;
   logic                    r_frame_start;

   logic                    w_boundary;
   logic [DIV_W-1:0]        w_next_div;
   logic [SLOT_W-1:0]       w_next_slot;
   logic                    w_next_blank;

   // r_run is low for the cycle after reset so the release edge itself
   // becomes the boundary into cycle 0 of slot 0.
   always_comb begin
      w_boundary  = 1'b0;
      w_next_div  = '0;
      w_next_slot = '0;
      if (!r_run) begin
         w_boundary = 1'b1;
      end else if (r_div_cnt == c_div_last) begin
         w_boundary  = 1'b1;
         w_next_slot = (r_slot == c_slot_last) ? '0 : r_slot + 1'b1;
      end else begin
         w_next_div  = r_div_cnt + 1'b1;
         w_next_slot = r_slot;
      end
   end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:1] w_lz;
   logic [NUM_DIGITS-1:0] w_blank_cand;
   logic [NUM_DIGITS-1:0] r_blank_vec;

   // w_lz[i]: nibbles i..top of the shadow are all zero
   for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign w_lz[gi] = (r_shadow[4*NUM_DIGITS-1:4*gi] == '0);
   end

   assign w_blank_cand = {w_lz, 1'b0};
   assign w_next_blank = w_boundary ? w_blank_cand[w_next_slot]
                                    : r_blank_vec[r_slot];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blank_vec <= '0;
      end else if (w_boundary) begin
         r_blank_vec <= w_blank_cand;
      end
   end
`else
   assign w_next_blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run         <= 1'b0;
         r_div_cnt     <= '0;
         r_slot        <= '0;
         r_shadow      <= '0;
         r_digit       <= 4'h0;
         r_anode       <= '1;
         r_frame_start <= 1'b0;
      end else begin
         r_run     <= 1'b1;
         r_div_cnt <= w_next_div;
         r_slot    <= w_next_slot;
         if (bus.load) begin
            r_shadow <= bus.value;
         end
         // Reads the pre-edge shadow, so a load on this edge shows next slot
         if (w_boundary) begin
            r_digit <= r_shadow[{w_next_slot, 2'b00} +: 4];
         end
         if ((w_next_div < c_dead) || w_next_blank) begin
            r_anode <= '1;
         end else begin
            r_anode <= ~(c_one << w_next_slot);
         end
         r_frame_start <= w_boundary && (w_next_slot == '0);
      end
   end

   assign bus.digit       = r_digit;
   assign bus.anode       = r_anode;
   assign bus.frame_start = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seven_segment_scanner                                             |
// | Directed bench: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_seven_segment_scanner;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   seven_segment_scanner_if #(.NUM_DIGITS(4)) bus ();

   seven_segment_scanner #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .DEAD_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full slot; the optional load is presented on the slot's first edge.
   task automatic run_slot(input string tag, input logic [3:0] exp_digit,
                           input logic [3:0] exp_lit, input bit exp_fs,
                           input bit do_load, input logic [15:0] v);
      if (do_load) begin
         bus.value = v;
         bus.load  = 1'b1;
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         bus.load = 1'b0;
         chk($sformatf("%s c%0d digit", tag, c), {12'h0, bus.digit}, {12'h0, exp_digit});
         chk($sformatf("%s c%0d anode", tag, c), {12'h0, bus.anode},
             (c < 2) ? 16'h000f : {12'h0, exp_lit});
         chk($sformatf("%s c%0d frame", tag, c), {15'h0, bus.frame_start},
             {15'h0, (c == 0) && exp_fs});
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.load  = 1'b0;
      bus.value = 16'h0;
      repeat (5) tick();
      chk("reset anode", {12'h0, bus.anode}, 16'h000f);
      chk("reset digit", {12'h0, bus.digit}, 16'h0000);
      chk("reset frame", {15'h0, bus.frame_start}, 16'h0000);
      rst_n = 1'b1;

      // first frame: 4321 captured on the slot 0->1 edge
      run_slot("f1s0", 4'h0, 4'b1110, 1'b1, 1'b0, 16'h0);
      run_slot("f1s1", 4'h0, 4'b1101, 1'b0, 1'b1, 16'h4321);
      run_slot("f1s2", 4'h3, 4'b1011, 1'b0, 1'b0, 16'h0);
      run_slot("f1s3", 4'h4, 4'b0111, 1'b0, 1'b0, 16'h0);

      run_slot("f2s0", 4'h1, 4'b1110, 1'b1, 1'b0, 16'h0);
      run_slot("f2s1", 4'h2, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("f2s2", 4'h3, 4'b1011, 1'b0, 1'b0, 16'h0);
      run_slot("f2s3", 4'h4, 4'b0111, 1'b0, 1'b0, 16'h0);

      // ABCD loaded on the slot 1->2 edge: slot 2 still shows the old 3
      run_slot("f3s0", 4'h1, 4'b1110, 1'b1, 1'b0, 16'h0);
      run_slot("f3s1", 4'h2, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("f3s2", 4'h3, 4'b1011, 1'b0, 1'b1, 16'hABCD);
      run_slot("f3s3", 4'hA, 4'b0111, 1'b0, 1'b0, 16'h0);

      run_slot("f4s0", 4'hD, 4'b1110, 1'b1, 1'b0, 16'h0);
      run_slot("f4s1", 4'hC, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("f4s2", 4'hB, 4'b1011, 1'b0, 1'b0, 16'h0);
      run_slot("f4s3", 4'hA, 4'b0111, 1'b0, 1'b0, 16'h0);

      run_slot("f5s0", 4'hD, 4'b1110, 1'b1, 1'b0, 16'h0);
      run_slot("f5s1", 4'hC, 4'b1101, 1'b0, 1'b0, 16'h0);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("f5s2 c%0d digit", c), {12'h0, bus.digit}, 16'h000B);
      end
      rst_n = 1'b0;
      tick();
      chk("midrst anode", {12'h0, bus.anode}, 16'h000f);
      chk("midrst digit", {12'h0, bus.digit}, 16'h0000);
      chk("midrst frame", {15'h0, bus.frame_start}, 16'h0000);
      tick();
      chk("midrst hold anode", {12'h0, bus.anode}, 16'h000f);
      rst_n = 1'b1;

      // 0050 captured on the release edge
      run_slot("b1s0", 4'h0, 4'b1110, 1'b1, 1'b1, 16'h0050);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      run_slot("b1s1", 4'h5, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("b1s2", 4'h0, 4'b1111, 1'b0, 1'b0, 16'h0);
      run_slot("b1s3", 4'h0, 4'b1111, 1'b0, 1'b0, 16'h0);

      run_slot("b2s0", 4'h0, 4'b1110, 1'b1, 1'b1, 16'h0000);
      run_slot("b2s1", 4'h0, 4'b1111, 1'b0, 1'b0, 16'h0);
      run_slot("b2s2", 4'h0, 4'b1111, 1'b0, 1'b0, 16'h0);
      run_slot("b2s3", 4'h0, 4'b1111, 1'b0, 1'b0, 16'h0);

      run_slot("b3s0", 4'h0, 4'b1110, 1'b1, 1'b1, 16'h0A00);
      run_slot("b3s1", 4'h0, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("b3s2", 4'hA, 4'b1011, 1'b0, 1'b0, 16'h0);
      run_slot("b3s3", 4'h0, 4'b1111, 1'b0, 1'b0, 16'h0);
`else
      run_slot("b1s1", 4'h5, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("b1s2", 4'h0, 4'b1011, 1'b0, 1'b0, 16'h0);
      run_slot("b1s3", 4'h0, 4'b0111, 1'b0, 1'b0, 16'h0);

      run_slot("b2s0", 4'h0, 4'b1110, 1'b1, 1'b0, 16'h0);
      run_slot("b2s1", 4'h5, 4'b1101, 1'b0, 1'b0, 16'h0);
      run_slot("b2s2", 4'h0, 4'b1011, 1'b0, 1'b0, 16'h0);
      run_slot("b2s3", 4'h0, 4'b0111, 1'b0, 1'b0, 16'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
